// File: rtl/aap_fetch_pkg.sv
// Shared fetch-stage definitions for the AAP pipeline (also used by execute).
package aap_fetch_pkg;

    localparam int DEF_PC_WIDTH    = 20;
    localparam int DEF_INSTR_WIDTH = 32;
    localparam int DEF_OFF_WIDTH   = 9;

    // pcjumpenable encodings; every other value is ignored
    localparam logic [2:0] PCJ_NONE = 3'd0;
    localparam logic [2:0] PCJ_REL  = 3'd1;
    localparam logic [2:0] PCJ_ABS  = 3'd2;

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        FETCH    = 2'd1,
        DRAIN    = 2'd2
    } fetch_state_t;

    function automatic logic is_redirect(input logic [2:0] pcj);
        return (pcj == PCJ_REL) || (pcj == PCJ_ABS);
    endfunction

endpackage

// File: rtl/fetch_output_buffer.sv
// Output register plus one-entry skid buffer between fetch and decode.
// Keeps order, never drops or duplicates, and holds the output stable while stalled.
module fetch_output_buffer #(
    parameter int                DATA_W     = 52,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              skid_full
);

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              load_out;

    // output register may take new data when empty or being consumed
    assign load_out  = !out_valid || out_ready;
    assign skid_full = skid_valid;

    // output/skid update: skid drains into output first so order is kept
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= RESET_DATA;
            skid_valid <= 1'b0;
            skid_data  <= RESET_DATA;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (load_out) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= in_valid;
                if (in_valid) skid_data <= in_data;
            end else begin
                out_valid <= in_valid;
                if (in_valid) out_data <= in_data;
            end
        end else if (in_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// AAP fetch stage: program counter, one-outstanding instruction memory reads,
// redirect handling and valid/ready delivery to decode.
// Optional: define FETCH_PERF_EN for perf_fetch_cnt / perf_flush_cnt / perf_stall_cnt.
module instruction_fetch #(
    parameter int                  PC_WIDTH    = aap_fetch_pkg::DEF_PC_WIDTH,
    parameter int                  INSTR_WIDTH = aap_fetch_pkg::DEF_INSTR_WIDTH,
    parameter int                  OFF_WIDTH   = aap_fetch_pkg::DEF_OFF_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [PC_WIDTH-1:0]    previous_programcounter,
    input  logic [2:0]             pcjumpenable,
    input  logic [OFF_WIDTH-1:0]   pcchange,
    input  logic [PC_WIDTH-1:0]    branch_pc,
    input  logic [PC_WIDTH-1:0]    pclocation
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            perf_fetch_cnt,
    output logic [31:0]            perf_flush_cnt,
    output logic [31:0]            perf_stall_cnt
`endif
);
    import aap_fetch_pkg::*;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    localparam int EXT_W = PC_WIDTH - OFF_WIDTH;

    fetch_state_t        state;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] target_q;
    logic                pending;
    logic                redirect;
    logic [PC_WIDTH-1:0] rel_off;
    logic [PC_WIDTH-1:0] redirect_target;
    logic                ack_taken;
    logic                buf_in_valid;
    logic                skid_full;
    fetch_entry_t        buf_in;
    fetch_entry_t        buf_out;

    assign redirect        = is_redirect(pcjumpenable);
    assign rel_off         = {{EXT_W{pcchange[OFF_WIDTH-1]}}, pcchange};
    assign redirect_target = (pcjumpenable == PCJ_REL) ? branch_pc + rel_off : pclocation;

    // address is always the PC: during DRAIN the PC still holds the old fetch address
    assign imem_addr = pc;
    assign ack_taken = imem_req && imem_ack;

    // request: held while outstanding, otherwise only when the skid has room
    always_comb begin
        imem_req = 1'b0;
        case (state)
            FETCH:   imem_req = pending || !skid_full;
            DRAIN:   imem_req = 1'b1;
            default: imem_req = 1'b0;
        endcase
    end

    // fetched words enter the buffer only on the correct path
    assign buf_in_valid = (state == FETCH) && ack_taken && !redirect;
    assign buf_in       = '{pc: pc, instr: imem_rdata};

    // PC and fetch FSM; a redirect with a read still in flight parks in DRAIN
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RST_WAIT;
            pc       <= RESET_PC;
            target_q <= RESET_PC;
            pending  <= 1'b0;
        end else begin
            case (state)
                RST_WAIT: begin
                    state <= FETCH;
                    if (redirect) pc <= redirect_target;
                end
                FETCH: begin
                    if (redirect) begin
                        pending <= 1'b0;
                        if (imem_req && !imem_ack) begin
                            state    <= DRAIN;
                            target_q <= redirect_target;
                        end else begin
                            pc <= redirect_target;
                        end
                    end else if (ack_taken) begin
                        pc      <= pc + PC_WIDTH'(1);
                        pending <= 1'b0;
                    end else begin
                        pending <= imem_req;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state <= FETCH;
                        pc    <= redirect ? redirect_target : target_q;
                    end else if (redirect) begin
                        target_q <= redirect_target;
                    end
                end
                default: state <= RST_WAIT;
            endcase
        end
    end

    fetch_output_buffer #(
        .DATA_W     ($bits(fetch_entry_t)),
        .RESET_DATA ({RESET_PC, {INSTR_WIDTH{1'b0}}})
    ) u_obuf (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect),
        .in_valid  (buf_in_valid),
        .in_data   (buf_in),
        .out_ready (instr_ready),
        .out_valid (instr_valid),
        .out_data  (buf_out),
        .skid_full (skid_full)
    );

    assign instr_out               = buf_out.instr;
    assign previous_programcounter = buf_out.pc;

`ifdef FETCH_PERF_EN
    logic consume;
    assign consume = instr_valid && instr_ready;

    // saturating event counters
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (consume && perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (redirect && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (instr_valid && !instr_ready && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table plus randomized run against
// an in-order delivery model (expected next PC per handshake, redirects retarget).
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [19:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [19:0] previous_programcounter;
    logic [2:0]  pcjumpenable = '0;
    logic [8:0]  pcchange = '0;
    logic [19:0] branch_pc = '0;
    logic [19:0] pclocation = '0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_flush_cnt, perf_stall_cnt;
`endif

    always #5 clock = ~clock;

    instruction_fetch dut (
        .clock                   (clock),
        .reset                   (reset),
        .imem_req                (imem_req),
        .imem_addr               (imem_addr),
        .imem_ack                (imem_ack),
        .imem_rdata              (imem_rdata),
        .instr_out               (instr_out),
        .instr_valid             (instr_valid),
        .instr_ready             (instr_ready),
        .previous_programcounter (previous_programcounter),
        .pcjumpenable            (pcjumpenable),
        .pcchange                (pcchange),
        .branch_pc               (branch_pc),
        .pclocation              (pclocation)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt          (perf_fetch_cnt),
        .perf_flush_cnt          (perf_flush_cnt),
        .perf_stall_cnt          (perf_stall_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] mem_word(input logic [19:0] a);
        return {a[11:0], a} ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, ack, rdy;
        logic [2:0]  pcj;
        logic [8:0]  off;
        logic [19:0] bpc, ploc;
        logic        e_req;
        logic [19:0] e_addr;
        logic        e_valid;
        logic        chk;
        logic [19:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    // expected fields describe outputs before this row's inputs are clocked in
    function automatic vec_t mk(input int rst, input int ack, input int rdy, input int pcj,
                                input int off, input int bpc, input int ploc, input int ereq,
                                input int eaddr, input int evld, input int epc, input int rz);
        vec_t v;
        v.rst = rst[0]; v.ack = ack[0]; v.rdy = rdy[0];
        v.pcj = 3'(pcj); v.off = 9'(off); v.bpc = 20'(bpc); v.ploc = 20'(ploc);
        v.e_req = ereq[0]; v.e_addr = 20'(eaddr); v.e_valid = evld[0];
        v.chk = evld[0] | rz[0];
        v.e_pc = 20'(epc);
        v.e_instr = rz[0] ? 32'h0 : mem_word(20'(epc));
        return v;
    endfunction

    function automatic logic [19:0] tgt(input logic [2:0] pcj, input logic [8:0] off,
                                        input logic [19:0] bpc, input logic [19:0] ploc);
        int o;
        o = off[8] ? int'(off) - 512 : int'(off);
        return (pcj == 3'd1) ? 20'(int'(bpc) + o) : ploc;
    endfunction

    vec_t vt[25];

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] exp_pc;
        logic [19:0] prev_addr;
        logic        prev_hold;
        int          delivered, n_stall, n_flush;

        //            rst ack rdy pcj off     bpc    ploc      req addr     vld pc      rz
        vt[0]  = mk(0, 0, 1, 0, 0,      0,     0,        0, 0,       0, 0,       1);
        vt[1]  = mk(0, 1, 1, 0, 0,      0,     0,        1, 0,       0, 0,       0);
        vt[2]  = mk(0, 1, 1, 0, 0,      0,     0,        1, 1,       1, 0,       0);
        vt[3]  = mk(0, 1, 1, 0, 0,      0,     0,        1, 2,       1, 1,       0);
        vt[4]  = mk(0, 1, 0, 0, 0,      0,     0,        1, 3,       1, 2,       0);
        vt[5]  = mk(0, 0, 0, 0, 0,      0,     0,        0, 4,       1, 2,       0);
        vt[6]  = mk(0, 0, 0, 0, 0,      0,     0,        0, 4,       1, 2,       0);
        vt[7]  = mk(0, 0, 1, 0, 0,      0,     0,        0, 4,       1, 2,       0);
        vt[8]  = mk(0, 1, 1, 0, 0,      0,     0,        1, 4,       1, 3,       0);
        vt[9]  = mk(0, 0, 1, 1, 'h1F8,  'h10,  0,        1, 5,       1, 4,       0);
        vt[10] = mk(0, 1, 1, 0, 0,      0,     0,        1, 5,       0, 0,       0);
        vt[11] = mk(0, 1, 1, 0, 0,      0,     0,        1, 8,       0, 0,       0);
        vt[12] = mk(0, 0, 0, 2, 0,      0,     'h123,    1, 9,       1, 8,       0);
        vt[13] = mk(0, 0, 1, 0, 0,      0,     0,        1, 9,       0, 0,       0);
        vt[14] = mk(0, 0, 1, 0, 0,      0,     0,        1, 9,       0, 0,       0);
        vt[15] = mk(0, 1, 1, 0, 0,      0,     0,        1, 9,       0, 0,       0);
        vt[16] = mk(0, 1, 0, 0, 0,      0,     0,        1, 'h123,   0, 0,       0);
        vt[17] = mk(0, 1, 0, 2, 0,      0,     'hFFFFF,  1, 'h124,   1, 'h123,   0);
        vt[18] = mk(0, 1, 1, 0, 0,      0,     0,        1, 'hFFFFF, 0, 0,       0);
        vt[19] = mk(0, 1, 1, 3, 0,      0,     'h55,     1, 0,       1, 'hFFFFF, 0);
        vt[20] = mk(0, 0, 1, 7, 0,      0,     0,        1, 1,       1, 0,       0);
        vt[21] = mk(0, 0, 1, 1, 'h005,  'h100, 0,        1, 1,       0, 0,       0);
        vt[22] = mk(1, 0, 1, 0, 0,      0,     0,        1, 1,       0, 0,       0);
        vt[23] = mk(0, 0, 1, 0, 0,      0,     0,        0, 0,       0, 0,       1);
        vt[24] = mk(0, 0, 1, 0, 0,      0,     0,        1, 0,       0, 0,       0);

        repeat (2) @(posedge clock);
        for (int i = 0; i < 25; i++) begin
            @(posedge clock); #1;
            check($sformatf("v%0d_req", i),   32'(imem_req),    32'(vt[i].e_req));
            check($sformatf("v%0d_addr", i),  32'(imem_addr),   32'(vt[i].e_addr));
            check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vt[i].e_valid));
            if (vt[i].chk) begin
                check($sformatf("v%0d_pc", i),    32'(previous_programcounter), 32'(vt[i].e_pc));
                check($sformatf("v%0d_instr", i), instr_out, vt[i].e_instr);
            end
            reset        = vt[i].rst;
            imem_ack     = vt[i].ack;
            instr_ready  = vt[i].rdy;
            pcjumpenable = vt[i].pcj;
            pcchange     = vt[i].off;
            branch_pc    = vt[i].bpc;
            pclocation   = vt[i].ploc;
            imem_rdata   = mem_word(imem_addr);
        end

        // randomized run against the delivery-order model
        @(posedge clock); #1;
        reset = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; pcjumpenable = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        exp_pc = 20'h0; prev_hold = 1'b0; prev_addr = '0;
        delivered = 0; n_stall = 0; n_flush = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock); #1;
            if (prev_hold) begin
                check("rnd_req_held", 32'(imem_req), 32'd1);
                check("rnd_addr_held", 32'(imem_addr), 32'(prev_addr));
            end
            instr_ready  = ($urandom % 4) != 0;
            imem_ack     = imem_req && (($urandom % 3) != 0);
            imem_rdata   = imem_ack ? mem_word(imem_addr) : $urandom;
            pcjumpenable = (($urandom % 8) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            pcchange     = 9'($urandom);
            branch_pc    = 20'($urandom);
            pclocation   = (($urandom % 2) == 0) ? (20'hFFFF0 | 20'($urandom_range(0, 15)))
                                                 : 20'($urandom);
            #1;
            if (instr_valid && instr_ready) begin
                check("rnd_pc", 32'(previous_programcounter), 32'(exp_pc));
                check("rnd_instr", instr_out, mem_word(exp_pc));
                exp_pc = exp_pc + 20'd1;
                delivered++;
            end
            if (instr_valid && !instr_ready) n_stall++;
            if (pcjumpenable == 3'd1 || pcjumpenable == 3'd2) begin
                exp_pc = tgt(pcjumpenable, pcchange, branch_pc, pclocation);
                n_flush++;
            end
            prev_hold = imem_req && !imem_ack;
            prev_addr = imem_addr;
        end
        @(posedge clock); #1;
        check("rnd_progress", 32'(delivered > 300), 32'd1);
`ifdef FETCH_PERF_EN
        check("perf_fetch", perf_fetch_cnt, 32'(delivered));
        check("perf_flush", perf_flush_cnt, 32'(n_flush));
        check("perf_stall", perf_stall_cnt, 32'(n_stall));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
